// File: rtl/cpu_pkg.sv
// Shared register-file types and constants for the writeback path.
// Holds the register widths, the zero-register constant and the writeback request record.
package cpu_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

    // Register 0 is hard-wired, so it never counts as a hazard match.
    function automatic logic addr_hit(input logic [REG_ADDR_W-1:0] query,
                                      input logic [REG_ADDR_W-1:0] target);
        return (query != REG_ZERO) && (query == target);
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus between execute/memory producers, the register file and the hazard unit.
// Optional WB_FWD_EN adds same-cycle bypass outputs for the two query ports.
interface wb_arbiter_if import cpu_pkg::*; #(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W
);
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic              wenable;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_newdata;
    logic [ADDR_W-1:0] qa_addr;
    logic [ADDR_W-1:0] qb_addr;
    logic              qa_pending;
    logic              qb_pending;
`ifdef WB_FWD_EN
    logic              qa_fwd_valid;
    logic [DATA_W-1:0] qa_fwd_data;
    logic              qb_fwd_valid;
    logic [DATA_W-1:0] qb_fwd_data;

    modport master (
        output alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data, qa_addr, qb_addr,
        input  ld_ready, wenable, c_addr, c_newdata, qa_pending, qb_pending,
        input  qa_fwd_valid, qa_fwd_data, qb_fwd_valid, qb_fwd_data
    );
    modport slave (
        input  alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data, qa_addr, qb_addr,
        output ld_ready, wenable, c_addr, c_newdata, qa_pending, qb_pending,
        output qa_fwd_valid, qa_fwd_data, qb_fwd_valid, qb_fwd_data
    );
`else
    modport master (
        output alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data, qa_addr, qb_addr,
        input  ld_ready, wenable, c_addr, c_newdata, qa_pending, qb_pending
    );
    modport slave (
        input  alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data, qa_addr, qb_addr,
        output ld_ready, wenable, c_addr, c_newdata, qa_pending, qb_pending
    );
`endif
endinterface

// File: rtl/wb_fifo.sv
// Circular queue of pending load/MDU writebacks with per-entry valid bits.
// Entries can be squashed by address; per-entry match vectors feed the pending lookups.
module wb_fifo #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    input  logic              squash_i,
    input  logic [ADDR_W-1:0] squash_addr_i,
    input  logic [ADDR_W-1:0] qa_addr_i,
    input  logic [ADDR_W-1:0] qb_addr_i,
    output logic              full_o,
    output logic              empty_o,
    output logic              head_valid_o,
    output logic [ADDR_W-1:0] head_addr_o,
    output logic [DATA_W-1:0] head_data_o,
    output logic [DEPTH-1:0]  qa_match_o,
    output logic [DEPTH-1:0]  qb_match_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              do_push, do_pop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign head_valid_o = valid_q[rd_ptr_q];
    assign head_addr_o  = addr_mem[rd_ptr_q];
    assign head_data_o  = data_mem[rd_ptr_q];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_mem[wr_ptr_q] <= push_addr_i;
            data_mem[wr_ptr_q] <= push_data_i;
        end
    end

    // Push and pop never target the same slot (that needs an empty or full queue).
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    valid_q[gi] <= 1'b0;
                else if (do_push && (wr_ptr_q == PTR_W'(gi)))
                    valid_q[gi] <= 1'b1;
                else if (do_pop && (rd_ptr_q == PTR_W'(gi)))
                    valid_q[gi] <= 1'b0;
                else if (squash_i && (addr_mem[gi] == squash_addr_i))
                    valid_q[gi] <= 1'b0;
            end
            assign qa_match_o[gi] = valid_q[gi] && (addr_mem[gi] == qa_addr_i);
            assign qb_match_o[gi] = valid_q[gi] && (addr_mem[gi] == qb_addr_i);
        end
    endgenerate

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write port arbiter: ALU results win, queued load/MDU results fill idle slots.
// Define WB_FWD_EN to expose same-cycle forwarding of the write landing this cycle.
module wb_arbiter import cpu_pkg::*; #(
    parameter int ADDR_W     = REG_ADDR_W,
    parameter int DATA_W     = REG_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    wb_arbiter_if.slave  bus
);
    logic              alu_take, ld_accept, ld_push, head_take;
    logic              fifo_full, fifo_empty, head_valid;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [FIFO_DEPTH-1:0] qa_match, qb_match;
    wb_req_t           out_q, out_d;

    assign alu_take  = bus.alu_valid && (bus.alu_addr != REG_ZERO);
    assign ld_accept = bus.ld_valid && bus.ld_ready;
    // A load colliding with a same-cycle ALU write is older, so it is accepted and dropped.
    assign ld_push   = ld_accept && (bus.ld_addr != REG_ZERO)
                     && !(alu_take && (bus.alu_addr == bus.ld_addr));
    assign head_take = !alu_take && !fifo_empty && head_valid;

    assign bus.ld_ready = !reset && !fifo_full;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (ld_push),
        .push_addr_i  (bus.ld_addr),
        .push_data_i  (bus.ld_data),
        .pop_i        (!alu_take),
        .squash_i     (alu_take),
        .squash_addr_i(bus.alu_addr),
        .qa_addr_i    (bus.qa_addr),
        .qb_addr_i    (bus.qb_addr),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .head_valid_o (head_valid),
        .head_addr_o  (head_addr),
        .head_data_o  (head_data),
        .qa_match_o   (qa_match),
        .qb_match_o   (qb_match)
    );

    // A popped squashed head leaves valid low, so that cycle issues no write.
    always_comb begin
        out_d       = out_q;
        out_d.valid = 1'b0;
        if (alu_take) begin
            out_d.valid = 1'b1;
            out_d.addr  = bus.alu_addr;
            out_d.data  = bus.alu_data;
        end else if (head_take) begin
            out_d.valid = 1'b1;
            out_d.addr  = head_addr;
            out_d.data  = head_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) out_q <= '0;
        else       out_q <= out_d;
    end

    assign bus.wenable   = out_q.valid;
    assign bus.c_addr    = out_q.addr;
    assign bus.c_newdata = out_q.data;

    assign bus.qa_pending = (bus.qa_addr != REG_ZERO) && (|qa_match)
                          || (out_q.valid && addr_hit(bus.qa_addr, out_q.addr))
                          || (alu_take && addr_hit(bus.qa_addr, bus.alu_addr))
                          || (ld_accept && addr_hit(bus.qa_addr, bus.ld_addr));
    assign bus.qb_pending = (bus.qb_addr != REG_ZERO) && (|qb_match)
                          || (out_q.valid && addr_hit(bus.qb_addr, out_q.addr))
                          || (alu_take && addr_hit(bus.qb_addr, bus.alu_addr))
                          || (ld_accept && addr_hit(bus.qb_addr, bus.ld_addr));

`ifdef WB_FWD_EN
    assign bus.qa_fwd_valid = out_q.valid && addr_hit(bus.qa_addr, out_q.addr);
    assign bus.qa_fwd_data  = out_q.data;
    assign bus.qb_fwd_valid = out_q.valid && addr_hit(bus.qb_addr, out_q.addr);
    assign bus.qb_fwd_data  = out_q.data;
`endif

endmodule
